// File: rtl/tdr_pkg.sv
// rtl/tdr_pkg.sv - shared types and timing constants for the TDR recovery controller
package tdr_pkg;

    typedef enum logic [2:0] {
        TDR_WARMUP = 3'd0,
        TDR_RUN    = 3'd1,
        TDR_RB0    = 3'd2,
        TDR_RB1    = 3'd3,
        TDR_FATAL  = 3'd4
    } tdr_state_e;

    localparam int TDR_WARMUP_CYC = 2;
    localparam int TDR_CLEAN_CYC  = 2;
    localparam int TDR_RETRY_W    = 4;

    typedef logic [TDR_RETRY_W-1:0] tdr_retry_t;

endpackage

// File: rtl/tdr_sat_cnt.sv
// rtl/tdr_sat_cnt.sv - saturating up-counter with asynchronous active-high reset
module tdr_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tdr_ctrl.sv
// rtl/tdr_ctrl.sv - TDR save/rollBack recovery controller with retry escalation to fatal
// Optional rollback event counter built when TDR_CTRL_CNT_EN is defined.
module tdr_ctrl
    import tdr_pkg::*;
#(
    parameter int NFF       = 8,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NFF-1:0]   fail,
    input  logic             en,
    input  logic             clr_fatal,
    output logic             save,
    output logic             rollBack,
    output logic             busy,
    output logic             fatal,
    output logic [CNT_W-1:0] rec_cnt
);

    localparam logic [2:0] ST_WARMUP = TDR_WARMUP;
    localparam logic [2:0] ST_RUN    = TDR_RUN;
    localparam logic [2:0] ST_RB0    = TDR_RB0;
    localparam logic [2:0] ST_RB1    = TDR_RB1;
    localparam logic [2:0] ST_FATAL  = TDR_FATAL;

    localparam int WU_W = (TDR_WARMUP_CYC > 1) ? $clog2(TDR_WARMUP_CYC) : 1;
    localparam int CL_W = (TDR_CLEAN_CYC > 1) ? $clog2(TDR_CLEAN_CYC) : 1;
    localparam logic [WU_W-1:0] WU_LAST  = WU_W'(TDR_WARMUP_CYC - 1);
    localparam logic [CL_W-1:0] CL_LAST  = CL_W'(TDR_CLEAN_CYC - 1);
    localparam tdr_retry_t      RETRY_MX = tdr_retry_t'(MAX_RETRY);

    logic [2:0]      state, state_nxt;
    logic [WU_W-1:0] wu_cnt;
    logic [CL_W-1:0] clean_cnt;
    tdr_retry_t      retry;
    logic            any_fail, hit, rb_start;

    assign any_fail = |fail;
    assign hit      = en && any_fail;

    always_comb begin
        state_nxt = state;
        rb_start  = 1'b0;
        case (state)
            ST_WARMUP: if (wu_cnt == WU_LAST) state_nxt = ST_RUN;
            ST_RUN: begin
                if (hit) begin
                    if (retry == RETRY_MX) begin
                        state_nxt = ST_FATAL;
                    end else begin
                        state_nxt = ST_RB0;
                        rb_start  = 1'b1;
                    end
                end
            end
            ST_RB0:   state_nxt = ST_RB1;
            ST_RB1:   state_nxt = ST_RUN;
            ST_FATAL: if (clr_fatal) state_nxt = ST_WARMUP;
            default:  state_nxt = ST_WARMUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WARMUP;
            wu_cnt    <= '0;
            clean_cnt <= '0;
            retry     <= '0;
        end else begin
            state  <= state_nxt;
            wu_cnt <= (state == ST_WARMUP) ? wu_cnt + 1'b1 : '0;
            // retry only forgets after enough uninterrupted clean RUN cycles
            if (state == ST_RUN && !hit) begin
                if (clean_cnt == CL_LAST) retry <= '0;
                else clean_cnt <= clean_cnt + 1'b1;
            end else begin
                clean_cnt <= '0;
            end
            if (rb_start) retry <= retry + 1'b1;
            if (state == ST_FATAL && clr_fatal) retry <= '0;
        end
    end

    // Outputs are registered copies of the next-state decode so they align with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            save     <= 1'b0;
            rollBack <= 1'b0;
            busy     <= 1'b1;
            fatal    <= 1'b0;
        end else begin
            save     <= (state_nxt == ST_RUN) || (state_nxt == ST_RB0);
            rollBack <= (state_nxt == ST_RB0) || (state_nxt == ST_RB1);
            busy     <= (state_nxt != ST_RUN);
            fatal    <= (state_nxt == ST_FATAL);
        end
    end

`ifdef TDR_CTRL_CNT_EN
    tdr_sat_cnt #(.W(CNT_W)) u_rec_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rb_start),
        .cnt (rec_cnt)
    );
`else
    assign rec_cnt = '0;
`endif

endmodule

// File: tb/tb_tdr_ctrl.sv
// tb/tb_tdr_ctrl.sv - randomized self-checking bench for tdr_ctrl against a behavioural model
module tb_tdr_ctrl;

    localparam int NFF       = 8;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NFF-1:0]   fail;
    logic             en;
    logic             clr_fatal;
    logic             save, rollBack, busy, fatal;
    logic [CNT_W-1:0] rec_cnt;

    logic       sat_rst, sat_inc;
    logic [1:0] sat_cnt;

    always #5 clk = ~clk;

    tdr_ctrl #(.NFF(NFF), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .fail      (fail),
        .en        (en),
        .clr_fatal (clr_fatal),
        .save      (save),
        .rollBack  (rollBack),
        .busy      (busy),
        .fatal     (fatal),
        .rec_cnt   (rec_cnt)
    );

    tdr_sat_cnt #(.W(2)) u_sat (
        .clk (clk),
        .rst (sat_rst),
        .inc (sat_inc),
        .cnt (sat_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: phase 0=warm-up, 1=running, 2=rollback A, 3=rollback B, 4=dead
    int m_phase, m_warm, m_streak, m_clean, m_recs;

    task automatic model_reset();
        m_phase = 0; m_warm = 0; m_streak = 0; m_clean = 0; m_recs = 0;
    endtask

    task automatic model_step(input logic [NFF-1:0] f, input logic e, input logic c);
        case (m_phase)
            0: begin
                m_warm++;
                if (m_warm == 2) begin m_phase = 1; m_clean = 0; end
            end
            1: begin
                if (e && (f != 0)) begin
                    m_clean = 0;
                    if (m_streak == MAX_RETRY) m_phase = 4;
                    else begin m_streak++; m_recs++; m_phase = 2; end
                end else begin
                    m_clean++;
                    if (m_clean >= 2) m_streak = 0;
                end
            end
            2: m_phase = 3;
            3: begin m_phase = 1; m_clean = 0; end
            default: if (c) begin m_phase = 0; m_warm = 0; m_streak = 0; end
        endcase
    endtask

    function automatic logic [31:0] exp_rec();
`ifdef TDR_CTRL_CNT_EN
        return (m_recs > (2**CNT_W - 1)) ? 32'(2**CNT_W - 1) : 32'(m_recs);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".save"},     32'(save),     32'((m_phase == 1) || (m_phase == 2)));
        check({tag, ".rollBack"}, 32'(rollBack), 32'((m_phase == 2) || (m_phase == 3)));
        check({tag, ".busy"},     32'(busy),     32'(m_phase != 1));
        check({tag, ".fatal"},    32'(fatal),    32'(m_phase == 4));
        check({tag, ".rec_cnt"},  32'(rec_cnt),  exp_rec());
    endtask

    task automatic cyc(input string tag, input logic [NFF-1:0] f, input logic e, input logic c);
        fail = f; en = e; clr_fatal = c;
        @(posedge clk);
        model_step(f, e, c);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [NFF-1:0] f;
        fail = '0; en = 1'b1; clr_fatal = 1'b0;
        rst = 1'b1; sat_rst = 1'b1; sat_inc = 1'b0;
        model_reset();
        #12;
        check("rst.save", 32'(save), 32'd0);
        check("rst.rollBack", 32'(rollBack), 32'd0);
        check("rst.busy", 32'(busy), 32'd1);
        check("rst.fatal", 32'(fatal), 32'd0);
        check("rst.rec_cnt", 32'(rec_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0; sat_rst = 1'b0;
        check_all("warm0");

        repeat (10) cyc("idle", '0, 1'b1, 1'b0);

        cyc("pulse", 8'h08, 1'b1, 1'b0);
        repeat (4) cyc("pulse_after", '0, 1'b1, 1'b0);

        cyc("masked", 8'h08, 1'b0, 1'b0);
        repeat (3) cyc("masked_after", '0, 1'b1, 1'b0);

        repeat (14) cyc("held", 8'hff, 1'b1, 1'b0);
        cyc("held_clr_off", 8'hff, 1'b1, 1'b0);
        cyc("clr", '0, 1'b1, 1'b1);
        repeat (4) cyc("clr_after", '0, 1'b1, 1'b0);

        repeat (10) begin
            cyc("spaced_hit", 8'h01, 1'b1, 1'b0);
            repeat (5) cyc("spaced_gap", '0, 1'b1, 1'b0);
        end

        repeat (400) begin
            f = ($urandom_range(0, 2) == 0) ? NFF'(1) << $urandom_range(0, NFF-1) : '0;
            cyc("rand", f, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
        end

        cyc("pre_arst_clr", '0, 1'b1, 1'b1);
        repeat (4) cyc("pre_arst", '0, 1'b1, 1'b0);
        cyc("arst_rb0", 8'h10, 1'b1, 1'b0);
        fail = '0;
        #2 rst = 1'b1;
        #1;
        check("arst.save", 32'(save), 32'd0);
        check("arst.rollBack", 32'(rollBack), 32'd0);
        check("arst.busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) cyc("post_arst", '0, 1'b1, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            sat_inc = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("sat_cnt", 32'(sat_cnt), 32'((i > 3) ? 3 : i));
        end
        sat_inc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdr_ctrl.md
# tdr_ctrl

Recovery controller for the time-double-redundancy (TDR) flip-flop array: the initiator side of the save/rollBack/fail interface that every TDR flip-flop block responds to. It OR-reduces the per-block `fail` flags, drives the shared `save` and `rollBack` lines through the checkpoint/rollback/speed-up sequence, and escalates to a sticky fatal state when errors recur faster than recovery completes. One instance sits at the top of each TDR-protected domain.

## Interface
- `NFF`, 8: number of TDR flip-flop blocks monitored (width of `fail`).
- `MAX_RETRY`, 3: back-to-back rollbacks tolerated; the next one goes fatal. Range 1..15.
- `CNT_W`, 16: width of the recovery event counter.

Ports:
- `clk`  in  1  system clock; all flops on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fail`  in  NFF  per-block error flags (d1 != d2), combinational from the blocks' registers.
- `en`  in  1  detection enable; 0 masks `fail` in RUN.
- `clr_fatal`  in  1  single-cycle pulse; leaves FATAL.
- `save`  out  1  checkpoint-shift enable broadcast to all blocks.
- `rollBack`  out  1  output-mux select broadcast to all blocks.
- `busy`  out  1  1 whenever state != RUN.
- `fatal`  out  1  sticky unrecoverable-error flag.
- `rec_cnt`  out  CNT_W  saturating count of rollbacks started.

## Operation
- `any_fail` = OR of `fail`. All outputs are registered, decoded from the state (Moore).
- States and outputs (`save`/`rollBack`):
  - WARMUP 0/0: blocks have no reset, so `fail` is ignored for 2 cycles; then -> RUN.
  - RUN 1/0: if `en` and `any_fail` -> RB0 (or FATAL, see retry rule).
  - RB0 1/1: blocks output the clean checkpoint (`recov`); `fail` ignored; -> RB1.
  - RB1 0/1: speed-up, blocks output `d1`; `fail` ignored; -> RUN.
  - FATAL 0/0: `fatal`=1; `clr_fatal` -> WARMUP; everything else ignored.
- Retry counter `retry` (4 bits):
  - Incremented on every RUN->RB0 transition.
  - Cleared after 2 consecutive fail-free RUN cycles (fail-free means `any_fail`=0 or `en`=0).
  - A fail in RUN with `retry` == `MAX_RETRY` -> FATAL instead of RB0, with no `rec_cnt` increment.
- `rec_cnt` increments on each RUN->RB0 and saturates at all-ones. It is cleared only by `rst`; leaving FATAL does not clear it.
- `clr_fatal` outside FATAL has no effect. `rst` overrides everything.
- Leaving FATAL clears `retry` and `fatal`.

## Timing
- Reset values: state WARMUP, `save`=0, `rollBack`=0, `busy`=1, `fatal`=0, `rec_cnt`=0, `retry`=0.
- Detection latency:
  - `any_fail` sampled high at edge t puts RB0 on the outputs from t+1 (`rollBack`=1 one cycle after `fail`).
  - RB1 occupies t+2.
  - `save`=1/`rollBack`=0 returns at t+3.
- Rollback window is exactly 2 cycles. A `fail` pulse inside it is lost by design.
- First RUN cycle after RB1: a fail there counts as a consecutive retry.
- WARMUP lasts exactly 2 cycles after `rst` deassertion or after leaving FATAL.
- `rst` asserted mid-RB0/RB1 drops `save` and `rollBack` to 0 asynchronously.

## Configuration
- `TDR_CTRL_CNT_EN` defined: `rec_cnt` counter present as described.
- `TDR_CTRL_CNT_EN` undefined: no counter flops; `rec_cnt` is tied to 0.
- FSM behaviour is identical in both builds.

## Structure
- Package `tdr_pkg`:
  - state enum (WARMUP, RUN, RB0, RB1, FATAL);
  - `TDR_WARMUP_CYC`=2, `TDR_CLEAN_CYC`=2;
  - retry counter width 4.
- Sub-module `tdr_sat_cnt`: parameterised saturating up-counter with async reset. Used for `rec_cnt`, and reusable by other TDR monitors.

## Test plan
- Reset, then `fail`=0 for 10 cycles -> `busy`=1 for 2 cycles, then `save`=1, `rollBack`=0, `rec_cnt`=0.
- Single `fail[3]` pulse in RUN at cycle t, `en`=1 -> `rollBack`=1 with `save`=1 at t+1; `save`=0 with `rollBack`=1 at t+2; RUN at t+3; `rec_cnt`=1.
- Same pulse with `en`=0 -> no state change, `rec_cnt`=0.
- `MAX_RETRY`=3, `fail` held high continuously -> 3 rollback sequences, then FATAL with `fatal`=1, `save`=0, `rec_cnt`=3. `clr_fatal` pulse -> 2 WARMUP cycles, then RUN with `fatal`=0.
- Two fails separated by 3 clean RUN cycles, repeated 10 times -> never FATAL; `rec_cnt`=10.
- `rst` asserted in RB0 -> `save`/`rollBack` drop to 0 before the next edge. `CNT_W`=2 with 5 spaced fails -> `rec_cnt` saturates at 3.
